tone_player: RTL and testbench
==============================

TONE_PLAYER -- requirements
Module: tone_player

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4: number of button inputs, 1..16.
REQ-002 SHALL have parameter IDX_W, default 2: width of note output; 2^IDX_W >= NUM_KEYS.
REQ-003 SHALL have parameter DIV_W, default 24: half-period counter width; must hold BASE_HALF << (NUM_KEYS-1).
REQ-004 SHALL have parameter BASE_HALF, default 16384: half-period of key 0, in clk cycles.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port button  input  NUM_KEYS  asynchronous key inputs, active-high.
REQ-008 SHALL have port switch  input  1  asynchronous octave-up select.
REQ-009 SHALL have port speaker  output  1  registered square-wave tone.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port note  output  IDX_W  index of key currently sounding; valid only when busy=1.

Function
REQ-012 SHALL pass button and switch through 2-flop synchronizers; all decisions use synchronized values only.
REQ-013 SHALL select the lowest-index set bit of synchronized button as the requested key; all-zero means no key.
REQ-014 SHALL compute half-period H = (BASE_HALF << idx) >> switch, forced to 1 if the result is 0.
REQ-015 SHALL implement states IDLE, PLAY, STOP.
REQ-016 IDLE: speaker=0, counter=0; on requested key present, latch idx into note, latch H, set speaker=1, enter PLAY on the same edge.
REQ-017 Latency: a press stable from edge t SHALL drive speaker high after edge t+2 (two sync edges, one FSM edge).
REQ-018 PLAY: counter increments each cycle; at counter == H-1 counter clears to 0 and speaker toggles, so each level lasts exactly H cycles.
REQ-019 PLAY: a different requested key or changed switch SHALL be applied (new note, new H) only on the high-to-low toggle edge; the high half in progress completes with the old H.
REQ-020 PLAY: when no key is requested and speaker=0, SHALL enter IDLE on that edge with counter cleared.
REQ-021 PLAY: when no key is requested and speaker=1, SHALL enter STOP; counter continues.
REQ-022 STOP: speaker holds 1 until counter == H-1, then speaker=0, counter=0, enter IDLE; key presses in STOP are ignored.
REQ-023 Key release and key change on the same toggle edge: release wins (REQ-020/021).
REQ-024 Counter SHALL never exceed H-1; no wrap-around of DIV_W occurs for legal parameters.
REQ-025 busy SHALL be registered alongside state; note SHALL hold its last value in IDLE.

Reset
REQ-026 While rst=1, independent of clk: state=IDLE, speaker=0, busy=0, note=0, counter=0, H=0, all synchronizer flops=0.
REQ-027 After rst deasserts, a key held throughout SHALL produce speaker high after the third rising edge (REQ-017 latency).
REQ-028 rst asserted mid-PLAY or mid-STOP SHALL force speaker=0 immediately with no tail completion.

Verification (BASE_HALF=4, NUM_KEYS=4, IDX_W=2)
REQ-029 Reset, button=0001, switch=0 held -> speaker high after 3rd edge, then 4 high/4 low repeating; note=0, busy=1.
REQ-030 button=0100 -> H=16; switch raised mid-high -> high half completes at 16 cycles, next period H=8.
REQ-031 button=0011 -> note=0, H=4 (lowest index wins); then 0010 mid-high -> 4-cycle high half finishes, then H=8, note=1.
REQ-032 Release during high half at counter=1 -> state STOP, speaker high 2 more cycles, then 0, busy=0; press during STOP ignored, accepted from IDLE.
REQ-033 Release during low half -> speaker stays 0, busy falls on the edge release is seen synchronized.
REQ-034 rst pulse (no clock edge) during PLAY with speaker=1 -> speaker=0, busy=0, note=0 immediately.

Source files
------------

// File: rtl/tone_player.sv
// Key-driven square-wave tone generator: the lowest pressed key selects a
// half-period of BASE_HALF << key, optionally halved by the octave switch.
module tone_player #(
    parameter int NUM_KEYS  = 4,
    parameter int IDX_W     = 2,
    parameter int DIV_W     = 24,
    parameter int BASE_HALF = 16384
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] button,
    input  logic                switch,
    output logic                speaker,
    output logic                busy,
    output logic [IDX_W-1:0]    note
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        STOP = 2'd2
    } state_t;

    logic [NUM_KEYS-1:0] btn_s1_q, btn_s2_q;
    logic                sw_s1_q, sw_s2_q;

    state_t              state_q;
    logic [DIV_W-1:0]    cnt_q;
    logic [DIV_W-1:0]    half_q;
    logic                speaker_q;
    logic                busy_q;
    logic [IDX_W-1:0]    note_q;

    logic                req_valid;
    logic [IDX_W-1:0]    req_idx;
    logic [DIV_W-1:0]    shifted;
    logic [DIV_W-1:0]    half_calc;
    logic                at_end;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1_q <= '0;
            btn_s2_q <= '0;
            sw_s1_q  <= 1'b0;
            sw_s2_q  <= 1'b0;
        end else begin
            btn_s1_q <= button;
            btn_s2_q <= btn_s1_q;
            sw_s1_q  <= switch;
            sw_s2_q  <= sw_s1_q;
        end
    end

    // Descending scan so the lowest set bit is the last (winning) assignment.
    always_comb begin
        req_valid = 1'b0;
        req_idx   = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (btn_s2_q[i]) begin
                req_valid = 1'b1;
                req_idx   = IDX_W'(i);
            end
        end
    end

    assign shifted   = (DIV_W'(BASE_HALF) << req_idx) >> sw_s2_q;
    assign half_calc = (shifted == '0) ? DIV_W'(1) : shifted;
    assign at_end    = (cnt_q == half_q - DIV_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            half_q    <= '0;
            speaker_q <= 1'b0;
            busy_q    <= 1'b0;
            note_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    speaker_q <= 1'b0;
                    if (req_valid) begin
                        note_q    <= req_idx;
                        half_q    <= half_calc;
                        speaker_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= PLAY;
                    end
                end
                PLAY: begin
                    if (!req_valid && !speaker_q) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (!req_valid) begin
                        // Release on the final high cycle finishes the tail right here.
                        if (at_end) begin
                            cnt_q     <= '0;
                            speaker_q <= 1'b0;
                            busy_q    <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            cnt_q   <= cnt_q + DIV_W'(1);
                            state_q <= STOP;
                        end
                    end else if (at_end) begin
                        cnt_q     <= '0;
                        speaker_q <= !speaker_q;
                        if (speaker_q) begin
                            note_q <= req_idx;
                            half_q <= half_calc;
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                STOP: begin
                    if (at_end) begin
                        cnt_q     <= '0;
                        speaker_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                default: begin
                    cnt_q     <= '0;
                    speaker_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign speaker = speaker_q;
    assign busy    = busy_q;
    assign note    = note_q;

endmodule

// File: tb/tb_tone_player.sv
// Directed bench for tone_player with BASE_HALF=4: a per-cycle vector table
// for start-up/release, then hand sequences for period changes, STOP and reset.
module tb_tone_player;

    localparam int NUM_KEYS  = 4;
    localparam int IDX_W     = 2;
    localparam int DIV_W     = 24;
    localparam int BASE_HALF = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NUM_KEYS-1:0] button;
    logic                switch;
    logic                speaker;
    logic                busy;
    logic [IDX_W-1:0]    note;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] btn;
        logic       sw;
        logic       exp_spk;
        logic       exp_busy;
        logic [1:0] exp_note;
    } vec_t;

    vec_t vecs[12];

    tone_player #(
        .NUM_KEYS (NUM_KEYS),
        .IDX_W    (IDX_W),
        .DIV_W    (DIV_W),
        .BASE_HALF(BASE_HALF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .switch (switch),
        .speaker(speaker),
        .busy   (busy),
        .note   (note)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance on falling edges until speaker reaches lvl; a timeout shows up as a failed check.
    task automatic wait_level(input logic lvl, input string name);
        int n;
        n = 0;
        while (speaker !== lvl && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(speaker), 32'(lvl));
    endtask

    // Count consecutive samples at lvl, starting from 'start' already seen; stops on the first differing sample.
    task automatic count_level(input logic lvl, input int start, output int n);
        n = start;
        while (n < 300) begin
            @(negedge clk);
            if (speaker !== lvl) break;
            n++;
        end
    endtask

    task automatic go_idle(input string name);
        int n;
        button = 4'b0000;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;

        vecs[0]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[1]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[2]  = '{4'b0001, 1'b0, 1'b1, 1'b1, 2'd0};
        vecs[3]  = '{4'b0001, 1'b0, 1'b1, 1'b1, 2'd0};
        vecs[4]  = '{4'b0001, 1'b0, 1'b1, 1'b1, 2'd0};
        vecs[5]  = '{4'b0001, 1'b0, 1'b1, 1'b1, 2'd0};
        vecs[6]  = '{4'b0001, 1'b0, 1'b0, 1'b1, 2'd0};
        vecs[7]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd0};
        vecs[8]  = '{4'b0000, 1'b0, 1'b0, 1'b1, 2'd0};
        vecs[9]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[10] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[11] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};

        rst    = 1'b1;
        button = 4'b0001;
        switch = 1'b0;
        repeat (3) @(negedge clk);
        check("reset speaker", 32'(speaker), 32'd0);
        check("reset busy",    32'(busy),    32'd0);
        check("reset note",    32'(note),    32'd0);
        rst = 1'b0;

        // Key 0 held through reset: rises after the 3rd edge, 4 high / 4 low, then release in the low half.
        for (int i = 0; i < 12; i++) begin
            button = vecs[i].btn;
            switch = vecs[i].sw;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d speaker", i), 32'(speaker), 32'(vecs[i].exp_spk));
            check($sformatf("vec%0d busy", i),    32'(busy),    32'(vecs[i].exp_busy));
            check($sformatf("vec%0d note", i),    32'(note),    32'(vecs[i].exp_note));
        end

        // Key 2 (H=16); octave switch raised mid-high takes effect from the next low half (H=8).
        button = 4'b0100;
        wait_level(1'b1, "A rise");
        check("A note", 32'(note), 32'd2);
        check("A busy", 32'(busy), 32'd1);
        repeat (4) @(negedge clk);
        switch = 1'b1;
        count_level(1'b1, 5, n);
        check("A high len H16", 32'(n), 32'd16);
        count_level(1'b0, 1, n);
        check("A low len H8", 32'(n), 32'd8);
        count_level(1'b1, 1, n);
        check("A high len H8", 32'(n), 32'd8);
        go_idle("A idle");
        switch = 1'b0;
        repeat (4) @(negedge clk);

        // Keys 0+1: lowest wins (H=4); switch to key 1 mid-high applies after the high half.
        button = 4'b0011;
        wait_level(1'b1, "B rise");
        check("B note lowest", 32'(note), 32'd0);
        @(negedge clk);
        button = 4'b0010;
        count_level(1'b1, 2, n);
        check("B high len H4", 32'(n), 32'd4);
        count_level(1'b0, 1, n);
        check("B low len H8", 32'(n), 32'd8);
        check("B note new", 32'(note), 32'd1);
        count_level(1'b1, 1, n);
        check("B high len H8", 32'(n), 32'd8);
        go_idle("B idle");
        repeat (4) @(negedge clk);

        // Release seen at counter=1 of a high half -> STOP tail, press during STOP ignored.
        button = 4'b0001;
        wait_level(1'b1, "C rise");
        count_level(1'b1, 1, n);
        check("C high len", 32'(n), 32'd4);
        repeat (3) @(negedge clk);
        button = 4'b0000;
        @(negedge clk);
        check("C rise again", 32'(speaker), 32'd1);
        @(negedge clk);
        button = 4'b0001;
        @(negedge clk);
        check("C stop speaker", 32'(speaker), 32'd1);
        check("C stop busy",    32'(busy),    32'd1);
        @(negedge clk);
        check("C tail speaker", 32'(speaker), 32'd1);
        @(negedge clk);
        check("C end speaker", 32'(speaker), 32'd0);
        check("C end busy",    32'(busy),    32'd0);
        @(negedge clk);
        check("C restart speaker", 32'(speaker), 32'd1);
        check("C restart busy",    32'(busy),    32'd1);

        // Move to key 1 so note is non-zero, then an asynchronous reset pulse between edges.
        button = 4'b0010;
        wait_level(1'b0, "D fall");
        wait_level(1'b1, "D rise");
        check("D note", 32'(note), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("D async speaker", 32'(speaker), 32'd0);
        check("D async busy",    32'(busy),    32'd0);
        check("D async note",    32'(note),    32'd0);
        #1;
        rst    = 1'b0;
        button = 4'b0000;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
